// File: rtl/seg_scan_display.sv
// 6-digit multiplexed common-anode 7-segment scanner.
// Frame-snapshotted BCD input, per-field blink, hour leading-zero blanking.
module seg_scan_display #(
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 40,
  parameter int HOUR_LZB  = 1
) (
  input  logic       CP,
  input  logic       RST,
  input  logic [7:0] Hbcd,
  input  logic [7:0] Mbcd,
  input  logic [7:0] Sbcd,
  input  logic [2:0] BlinkSel,
  output logic [5:0] An,
  output logic [6:0] Seg,
  output logic       Dp
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic [7:0]    r_snap_h;
  logic [7:0]    r_snap_m;
  logic [7:0]    r_snap_s;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic          w_blink_en;
  logic          w_sep;
  logic [6:0]    w_seg;
  logic          w_blank;

  assign w_tick = (r_presc == PW'(CLK_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 3'd5);

  // Prescaler, digit index, snapshot and blink timebase
  always_ff @(posedge CP) begin
    if (RST) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_frame  <= '0;
      r_phase  <= 1'b0;
      r_snap_h <= '0;
      r_snap_m <= '0;
      r_snap_s <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      if (w_wrap) begin
        r_snap_h <= Hbcd;
        r_snap_m <= Mbcd;
        r_snap_s <= Sbcd;
        if (r_frame == FW'(BLINK_DIV - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  // Select the digit nibble, its blink field and separator point
  always_comb begin
    w_nib      = 4'h0;
    w_blink_en = 1'b0;
    w_sep      = 1'b0;
    unique case (r_idx)
      3'd0: begin w_nib = r_snap_s[3:0]; w_blink_en = BlinkSel[0]; end
      3'd1: begin w_nib = r_snap_s[7:4]; w_blink_en = BlinkSel[0]; end
      3'd2: begin
        w_nib = r_snap_m[3:0]; w_blink_en = BlinkSel[1]; w_sep = 1'b1;
      end
      3'd3: begin w_nib = r_snap_m[7:4]; w_blink_en = BlinkSel[1]; end
      3'd4: begin
        w_nib = r_snap_h[3:0]; w_blink_en = BlinkSel[2]; w_sep = 1'b1;
      end
      3'd5: begin w_nib = r_snap_h[7:4]; w_blink_en = BlinkSel[2]; end
      default: begin w_nib = 4'h0; w_blink_en = 1'b0; end
    endcase
  end

  // Active-low segment decode; non-BCD shows a dash
  always_comb begin
    w_seg = 7'h3F;
    case (w_nib)
      4'd0: w_seg = 7'h40;
      4'd1: w_seg = 7'h79;
      4'd2: w_seg = 7'h24;
      4'd3: w_seg = 7'h30;
      4'd4: w_seg = 7'h19;
      4'd5: w_seg = 7'h12;
      4'd6: w_seg = 7'h02;
      4'd7: w_seg = 7'h78;
      4'd8: w_seg = 7'h00;
      4'd9: w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

  assign w_blank = (r_phase && w_blink_en) ||
                   ((HOUR_LZB == 1) && (r_idx == 3'd5) &&
                    (r_snap_h[7:4] == 4'h0));

  // Registered output stage
  always_ff @(posedge CP) begin
    if (RST || w_blank) begin
      r_an  <= 6'h3F;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(6'b000001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~w_sep;
    end
  end

  assign An  = r_an;
  assign Seg = r_seg;
  assign Dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: two instances (LZB on/off),
// per-cycle expected An/Seg/Dp queued by stimulus, checked by a monitor.
module tb_seg_scan_display;

  logic       CP;
  logic       RST;
  logic [7:0] Hbcd, Mbcd, Sbcd;
  logic [2:0] BlinkSel;
  logic [5:0] An_a, An_b;
  logic [6:0] Seg_a, Seg_b;
  logic       Dp_a, Dp_b;

  seg_scan_display #(.CLK_DIV(4), .BLINK_DIV(2), .HOUR_LZB(1)) u_dut (
    .CP(CP), .RST(RST), .Hbcd(Hbcd), .Mbcd(Mbcd), .Sbcd(Sbcd),
    .BlinkSel(BlinkSel), .An(An_a), .Seg(Seg_a), .Dp(Dp_a)
  );

  seg_scan_display #(.CLK_DIV(4), .BLINK_DIV(2), .HOUR_LZB(0)) u_dut_nl (
    .CP(CP), .RST(RST), .Hbcd(Hbcd), .Mbcd(Mbcd), .Sbcd(Sbcd),
    .BlinkSel(BlinkSel), .An(An_b), .Seg(Seg_b), .Dp(Dp_b)
  );

  typedef struct {
    int         cyc;
    logic [13:0] a;
    logic [13:0] b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [13:0] BLK = {6'h3F, 7'h7F, 1'b1};

  initial CP = 1'b0;
  always #5 CP = ~CP;

  always @(posedge CP) cyc <= cyc + 1;

  task automatic chk(string nm, int c, logic [13:0] act, logic [13:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got An=%h Seg=%h Dp=%b expected An=%h Seg=%h Dp=%b",
               nm, c, act[13:8], act[7:1], act[0], ex[13:8], ex[7:1], ex[0]);
    end
  endtask

  task automatic one(int c, logic [13:0] a, logic [13:0] b);
    exp_t x;
    x.cyc = c; x.a = a; x.b = b;
    q.push_back(x);
  endtask

  task automatic slot(int c, logic [13:0] a, logic [13:0] b);
    for (int k = 0; k < 4; k++) one(c + k, a, b);
  endtask

  task automatic frame(int c, logic [6:0] s0, logic [6:0] s1,
                       logic [6:0] s2, logic [6:0] s3, logic [6:0] s4,
                       logic [6:0] s5, bit dark23, bit lzb);
    logic [13:0] v;
    v = {6'h3E, s0, 1'b1}; slot(c, v, v);
    v = {6'h3D, s1, 1'b1}; slot(c + 4, v, v);
    v = dark23 ? BLK : {6'h3B, s2, 1'b0}; slot(c + 8, v, v);
    v = dark23 ? BLK : {6'h37, s3, 1'b1}; slot(c + 12, v, v);
    v = {6'h2F, s4, 1'b0}; slot(c + 16, v, v);
    v = {6'h1F, s5, 1'b1}; slot(c + 20, lzb ? BLK : v, v);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge CP);
  endtask

  // Monitor: pop and compare expected outputs for this cycle
  always @(negedge CP) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_entry cyc=%0d seen at cyc=%0d", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("lzb_on", cyc, {An_a, Seg_a, Dp_a}, e.a);
      chk("lzb_off", cyc, {An_b, Seg_b, Dp_b}, e.b);
    end
    if (cyc > 0) begin
      n_chk++;
      if ($countones(~An_a) > 1 || $countones(~An_b) > 1) begin
        n_fail++;
        $display("FAIL an_onehot cyc=%0d got An=%h/%h expected at most one low",
                 cyc, An_a, An_b);
      end
    end
  end

  initial begin
    RST = 1'b1;
    Hbcd = 8'h12; Mbcd = 8'h34; Sbcd = 8'h56;
    BlinkSel = 3'b000;

    for (int c = 1; c <= 3; c++) one(c, BLK, BLK);
    frame(4,   7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 0, 1);
    frame(28,  7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 0, 0);
    frame(52,  7'h78, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 1, 0);
    frame(76,  7'h3F, 7'h3F, 7'h19, 7'h30, 7'h10, 7'h40, 1, 1);
    frame(100, 7'h3F, 7'h3F, 7'h19, 7'h30, 7'h10, 7'h40, 0, 1);
    frame(124, 7'h3F, 7'h3F, 7'h19, 7'h30, 7'h10, 7'h40, 0, 1);
    slot(148, {6'h3E, 7'h3F, 1'b1}, {6'h3E, 7'h3F, 1'b1});
    slot(152, {6'h3D, 7'h3F, 1'b1}, {6'h3D, 7'h3F, 1'b1});
    slot(156, BLK, BLK);
    one(160, BLK, BLK);
    one(161, BLK, BLK);
    frame(162, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 0, 1);
    frame(186, 7'h3F, 7'h3F, 7'h19, 7'h30, 7'h10, 7'h40, 0, 1);

    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(36);
    Sbcd = 8'h57;
    wait_cyc(51);
    BlinkSel = 3'b010;
    wait_cyc(60);
    Hbcd = 8'h09;
    Sbcd = 8'hAF;
    wait_cyc(160);
    RST = 1'b1;
    wait_cyc(161);
    RST = 1'b0;
    wait_cyc(212);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
